// File: rtl/npu_iob_pkg.sv
// Shared io_buffer AGU definitions: geometry widths, FSM encoding, tile config.
package npu_iob_pkg;

   localparam int unsigned AWD   = 12;
   localparam int unsigned DIM_W = 8;
   localparam int unsigned PAD_W = 2;
   localparam int unsigned PLN_W = 4;
   // One extra bit so that H+2P / W+2P cannot overflow the scan counters.
   localparam int unsigned CNT_W = DIM_W + 1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } agu_state_e;

   typedef struct packed {
      logic [AWD-1:0]   base;
      logic [DIM_W-1:0] width;
      logic [DIM_W-1:0] height;
      logic [PAD_W-1:0] pad;
      logic [AWD-1:0]   row_stride;
      logic [PLN_W-1:0] planes;
      logic [AWD-1:0]   plane_stride;
   } iob_cfg_t;

   function automatic logic cfg_legal(input iob_cfg_t cfg);
      return (cfg.width != '0) && (cfg.height != '0) && (cfg.planes != '0);
   endfunction

   // Padded extent of one dimension: dim + 2*pad.
   function automatic logic [CNT_W-1:0] padded_extent(input logic [DIM_W-1:0] dim,
                                                      input logic [PAD_W-1:0] pad);
      return CNT_W'(dim) + CNT_W'({pad, 1'b0});
   endfunction

endpackage

// File: rtl/iob_rd_if.sv
// io_buffer internal read port: address/enables towards the buffer, stall back.
interface iob_rd_if;
   import npu_iob_pkg::*;

   logic [AWD-1:0] raddr;
   logic           rd_en;
   logic           pad_en;
   logic           wsel;
   logic           stall;

   modport master (output raddr, output rd_en, output pad_en, output wsel, input stall);
   modport slave  (input raddr, input rd_en, input pad_en, input wsel, output stall);

endinterface

// File: rtl/iob_scan_cnt.sv
// Nested column/row/plane raster counters with wrap, last-beat and pad-region detect.
// When init_i is high the current position is taken as (0,0,0) regardless of state,
// which lets the first beat issue on the same edge that samples start.
module iob_scan_cnt
   import npu_iob_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             init_i,
   input  logic             adv_i,
   input  logic [DIM_W-1:0] width_i,
   input  logic [DIM_W-1:0] height_i,
   input  logic [PAD_W-1:0] pad_i,
   input  logic [PLN_W-1:0] planes_i,
   output logic             pad_beat_o,
   output logic             row_int_o,
   output logic             col_last_o,
   output logic             row_last_o,
   output logic             last_o
);

   logic [CNT_W-1:0] c_q, c_d, c_cur;
   logic [CNT_W-1:0] r_q, r_d, r_cur;
   logic [PLN_W-1:0] p_q, p_d, p_cur;
   logic [CNT_W-1:0] pad_ext, col_end, row_end;
   logic             col_int, plane_last;

   assign c_cur = init_i ? '0 : c_q;
   assign r_cur = init_i ? '0 : r_q;
   assign p_cur = init_i ? '0 : p_q;

   assign pad_ext = CNT_W'(pad_i);
   assign col_end = padded_extent(width_i, pad_i) - CNT_W'(1);
   assign row_end = padded_extent(height_i, pad_i) - CNT_W'(1);

   assign row_int_o  = (r_cur >= pad_ext) && (r_cur < CNT_W'(height_i) + pad_ext);
   assign col_int    = (c_cur >= pad_ext) && (c_cur < CNT_W'(width_i) + pad_ext);
   assign pad_beat_o = !(row_int_o && col_int);

   assign col_last_o = (c_cur == col_end);
   assign row_last_o = (r_cur == row_end);
   assign plane_last = (p_cur == planes_i - PLN_W'(1));
   assign last_o     = col_last_o && row_last_o && plane_last;

   // Raster advance: column fastest, then row, then plane.
   always_comb begin
      c_d = c_q;
      r_d = r_q;
      p_d = p_q;
      if (adv_i) begin
         c_d = c_cur + CNT_W'(1);
         r_d = r_cur;
         p_d = p_cur;
         if (col_last_o) begin
            c_d = '0;
            r_d = r_cur + CNT_W'(1);
            if (row_last_o) begin
               r_d = '0;
               p_d = plane_last ? '0 : p_cur + PLN_W'(1);
            end
         end
      end else if (init_i) begin
         c_d = '0;
         r_d = '0;
         p_d = '0;
      end
   end

   // Counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         c_q <= '0;
         r_q <= '0;
         p_q <= '0;
      end else begin
         c_q <= c_d;
         r_q <= r_d;
         p_q <= p_d;
      end
   end

endmodule

// File: rtl/iob_rd_agu.sv
// io_buffer read address generator: walks a padded tile in raster order, issuing
// one pad or read beat per unstalled cycle. Addresses come from incremental adders.
module iob_rd_agu
   import npu_iob_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [AWD-1:0]   i_base_addr,
   input  logic [DIM_W-1:0] i_width,
   input  logic [DIM_W-1:0] i_height,
   input  logic [PAD_W-1:0] i_pad,
   input  logic [AWD-1:0]   i_row_stride,
   input  logic [PLN_W-1:0] i_planes,
   input  logic [AWD-1:0]   i_plane_stride,
   iob_rd_if.master         iob,
   output logic             o_busy,
   output logic             o_last,
   output logic             o_done,
   output logic             o_err
);

   agu_state_e     state_q;
   iob_cfg_t       cfg_in, cfg_q, cfg_eff;
   logic [AWD-1:0] plane_base_q, row_base_q, col_addr_q;
   logic [AWD-1:0] pb_d, rb_d, ca_d;
   logic [AWD-1:0] cur_pb, cur_rb, cur_ca;
   logic [AWD-1:0] raddr_q;
   logic           rd_en_q, pad_en_q, busy_q, last_q, done_q, err_q, err_pend_q;
   logic           idle, start_ok, issue;
   logic           pad_beat, row_int, col_last, row_last, scan_last;

   assign cfg_in = '{base:         i_base_addr,
                     width:        i_width,
                     height:       i_height,
                     pad:          i_pad,
                     row_stride:   i_row_stride,
                     planes:       i_planes,
                     plane_stride: i_plane_stride};

   assign idle     = (state_q == StIdle);
   // In IDLE the live inputs describe the beat issued on the start edge.
   assign cfg_eff  = idle ? cfg_in : cfg_q;
   assign start_ok = idle && i_start && cfg_legal(cfg_in);
   assign issue    = (start_ok || (state_q == StRun)) && !iob.stall;

   assign cur_pb = idle ? cfg_eff.base : plane_base_q;
   assign cur_rb = idle ? cfg_eff.base : row_base_q;
   assign cur_ca = idle ? cfg_eff.base : col_addr_q;

   iob_scan_cnt u_scan (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .init_i     (idle),
      .adv_i      (issue),
      .width_i    (cfg_eff.width),
      .height_i   (cfg_eff.height),
      .pad_i      (cfg_eff.pad),
      .planes_i   (cfg_eff.planes),
      .pad_beat_o (pad_beat),
      .row_int_o  (row_int),
      .col_last_o (col_last),
      .row_last_o (row_last),
      .last_o     (scan_last)
   );

   // Address adders: column step on interior beats, row step after interior rows,
   // plane step on plane wrap (which also rebases row and column).
   always_comb begin
      pb_d = cur_pb;
      rb_d = cur_rb;
      ca_d = cur_ca;
      if (issue) begin
         if (col_last) begin
            if (row_last) begin
               pb_d = cur_pb + cfg_eff.plane_stride;
               rb_d = pb_d;
               ca_d = pb_d;
            end else begin
               rb_d = cur_rb + (row_int ? cfg_eff.row_stride : '0);
               ca_d = rb_d;
            end
         end else if (!pad_beat) begin
            ca_d = cur_ca + AWD'(1);
         end
      end
   end

   // Control FSM with registered beat and status outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         cfg_q        <= '0;
         plane_base_q <= '0;
         row_base_q   <= '0;
         col_addr_q   <= '0;
         raddr_q      <= '0;
         rd_en_q      <= 1'b0;
         pad_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_pend_q   <= 1'b0;
      end else begin
         rd_en_q      <= 1'b0;
         pad_en_q     <= 1'b0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         plane_base_q <= pb_d;
         row_base_q   <= rb_d;
         col_addr_q   <= ca_d;

         if (issue) begin
            rd_en_q  <= !pad_beat;
            pad_en_q <= pad_beat;
            last_q   <= scan_last;
            // Pad beats leave the address untouched.
            if (!pad_beat) raddr_q <= cur_ca;
         end

         unique case (state_q)
            StIdle: begin
               if (i_start) begin
                  if (start_ok) begin
                     cfg_q <= cfg_in;
                     // A 1x1x1 tile finishes on the start edge itself.
                     if (issue && scan_last) begin
                        state_q <= StDone;
                     end else begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                     end
                  end else begin
                     state_q    <= StDone;
                     err_pend_q <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (issue && scan_last) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
               end
            end
            StDone: begin
               done_q     <= 1'b1;
               err_q      <= err_pend_q;
               err_pend_q <= 1'b0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign iob.raddr  = raddr_q;
   assign iob.rd_en  = rd_en_q;
   assign iob.pad_en = pad_en_q;
   // The read side owns the buffer select only while scanning.
   assign iob.wsel   = busy_q;
   assign o_busy     = busy_q;
   assign o_last     = last_q;
   assign o_done     = done_q;
   assign o_err      = err_q;

endmodule
